// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a one-deep holding register and a
// STATUS register read back with the same one-cycle registered timing as RAM.
module uart_tx_mmio #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_wstrb,
    input  logic        io_rstrb,
    output logic [31:0] io_rdata,
    output logic        txd,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [1:0]  SEL_DATA   = 2'd0;
    localparam logic [1:0]  SEL_STATUS = 2'd1;

    state_t      state_q, state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;
    logic        overrun_q, overrun_d;
    logic        txd_q, txd_d;
    logic [31:0] rdata_q, rdata_d;

    logic bit_end;
    logic load;
    logic wr_data;
    logic rd_status;
    logic unused_bits;

    assign unused_bits = ^{io_addr[31:4], io_addr[1:0], io_wdata[31:8]};

    assign busy     = (state_q != S_IDLE) | hold_valid_q;
    assign txd      = txd_q;
    assign io_rdata = rdata_q;

    // Shifter: load happens from IDLE, or straight out of STOP for gapless frames.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        load      = 1'b0;
        bit_end   = (bit_cnt_q == BIT_LAST);

        case (state_q)
            S_IDLE: begin
                load = hold_valid_q;
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            default: begin
                if (bit_end) begin
                    load    = hold_valid_q;
                    state_d = S_IDLE;
                end
            end
        endcase

        if (state_q != S_IDLE) begin
            bit_cnt_d = bit_end ? 16'd0 : bit_cnt_q + 16'd1;
        end

        if (load) begin
            shift_d   = hold_q;
            state_d   = S_START;
            bit_cnt_d = 16'd0;
        end

        // txd is the registered image of the next state, so it changes only on edges.
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // Bus side: holding register, sticky overrun and registered read data.
    always_comb begin
        wr_data      = io_wstrb && (io_addr[3:2] == SEL_DATA);
        rd_status    = io_rstrb && (io_addr[3:2] == SEL_STATUS);
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q & ~load;
        overrun_d    = overrun_q & ~rd_status;
        rdata_d      = rdata_q;

        if (wr_data) begin
            if (!hold_valid_q || load) begin
                hold_d       = io_wdata[7:0];
                hold_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (io_rstrb) begin
            rdata_d = rd_status ? {29'b0, overrun_q, hold_valid_q, busy} : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            txd_q        <= 1'b1;
            rdata_q      <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            overrun_q    <= overrun_d;
            txd_q        <= txd_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed scenarios plus random bus
// traffic, all scored against a frame-timeline model of the transmitter.
module tb_uart_tx_mmio;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] io_addr = 32'h0;
    logic [31:0] io_wdata = 32'h0;
    logic        io_wstrb = 1'b0;
    logic        io_rstrb = 1'b0;
    logic [31:0] io_rdata;
    logic        txd;
    logic        busy;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    uart_tx_mmio #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .io_addr  (io_addr),
        .io_wdata (io_wdata),
        .io_wstrb (io_wstrb),
        .io_rstrb (io_rstrb),
        .io_rdata (io_rdata),
        .txd      (txd),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: each accepted byte becomes a frame with a write cycle w and a
    // start cycle s; it occupies cycles [s, s+10*C). Cycle t = state after edge t.
    typedef struct {
        int         w;
        int         s;
        logic [7:0] b;
    } frame_t;

    frame_t      frames[$];
    bit          m_ovr = 1'b0;
    logic [31:0] last_rdata = 32'h0;

    function automatic int end_last();
        if (frames.size() == 0) return 0;
        return frames[$].s + 10 * C;
    endfunction

    function automatic logic exp_txd(int t);
        foreach (frames[i]) begin
            if (t >= frames[i].s && t < frames[i].s + 10 * C) begin
                int o = (t - frames[i].s) / C;
                if (o == 0) return 1'b0;
                if (o == 9) return 1'b1;
                return frames[i].b[o - 1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(int t);
        foreach (frames[i])
            if (t >= frames[i].w && t < frames[i].s + 10 * C) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_full(int t);
        foreach (frames[i])
            if (t >= frames[i].w && t < frames[i].s) return 1'b1;
        return 1'b0;
    endfunction

    // Returns 0 when the byte is dropped because an earlier one is still waiting.
    function automatic bit model_write(int m, logic [7:0] b);
        int e;
        int s;
        foreach (frames[i])
            if (frames[i].w < m && frames[i].s > m) return 1'b0;
        e = end_last();
        s = (m + 1 > e) ? m + 1 : e;
        frames.push_back('{w: m, s: s, b: b});
        return 1'b1;
    endfunction

    function automatic void model_reset();
        frames.delete();
        m_ovr      = 1'b0;
        last_rdata = 32'h0;
    endfunction

    // Continuous scoreboard of the serial line and busy flag.
    always @(negedge clk) begin
        if (!resetn) begin
            n_checks++;
            if (txd !== 1'b1 || busy !== 1'b0 || io_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d: txd=%b busy=%b rdata=%h, required 1/0/0",
                         cyc, txd, busy, io_rdata);
            end
        end else begin
            n_checks++;
            if (txd !== exp_txd(cyc)) begin
                n_fail++;
                $display("FAIL txd cyc=%0d: got %b, required %b", cyc, txd, exp_txd(cyc));
            end
            n_checks++;
            if (busy !== exp_busy(cyc)) begin
                n_fail++;
                $display("FAIL busy cyc=%0d: got %b, required %b", cyc, busy, exp_busy(cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run still active at cycle %0d, required completion", cyc);
        $fatal(1);
    end

    task automatic bus_cycle(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] data, output int edge_n,
                             output logic [31:0] got, output logic [31:0] exp);
        @(negedge clk);
        edge_n = cyc + 1;
        if (rd) exp = (addr[3:2] == 2'd1) ? {29'b0, m_ovr, exp_full(cyc), exp_busy(cyc)} : 32'h0;
        else    exp = last_rdata;
        last_rdata = exp;
        if (rd && addr[3:2] == 2'd1) m_ovr = 1'b0;
        if (wr && addr[3:2] == 2'd0)
            if (!model_write(edge_n, data[7:0])) m_ovr = 1'b1;
        io_addr  = addr;
        io_wdata = data;
        io_wstrb = wr;
        io_rstrb = rd;
        @(posedge clk);
        #1;
        got      = io_rdata;
        io_wstrb = 1'b0;
        io_rstrb = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Independent serial capture: samples the middle of each bit period.
    task automatic capture_frame(input int s, output logic [7:0] data, output logic framing_ok);
        logic [9:0] bits;
        for (int k = 0; k < 10; k++) begin
            wait_until(s + k * C + C / 2);
            bits[k] = txd;
        end
        data       = bits[8:1];
        framing_ok = (bits[0] == 1'b0) && (bits[9] == 1'b1);
    endtask

    task automatic test_reset();
        int          e;
        logic [31:0] g, x;
        resetn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: txd=%b busy=%b, required 1/0", txd, busy);
        end
        bus_cycle(1'b0, 1'b1, 32'h4, 32'h0, e, g, x);
        n_checks++;
        if (g !== 32'h0 || g !== x) begin
            n_fail++;
            $display("FAIL reset_status: got %h, required %h", g, 32'h0);
        end
    endtask

    task automatic test_single();
        int          e, s;
        logic [31:0] g, x;
        logic [7:0]  d;
        logic        ok;
        bus_cycle(1'b1, 1'b0, 32'h0, 32'h55, e, g, x);
        s = e + 1;
        capture_frame(s, d, ok);
        n_checks++;
        if (d !== 8'h55 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL single_frame: byte %h framing %b, required 55 / 1", d, ok);
        end
        wait_until(s + 39);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_last: got %b, required 1", busy);
        end
        wait_until(s + 40);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_end: got %b, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int          e1, e, s1;
        logic [31:0] g, x;
        logic [7:0]  d;
        logic        ok;
        bus_cycle(1'b1, 1'b0, 32'h0, 32'hA3, e1, g, x);
        s1 = e1 + 1;
        bus_cycle(1'b0, 1'b1, 32'h4, 32'h0, e, g, x);
        n_checks++;
        if (g !== x || g[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_full_before_load: got %h, required %h", g, x);
        end
        bus_cycle(1'b1, 1'b0, 32'h0, 32'h0F, e, g, x);
        bus_cycle(1'b0, 1'b1, 32'h4, 32'h0, e, g, x);
        n_checks++;
        if (g !== x || g !== 32'h3) begin
            n_fail++;
            $display("FAIL b2b_full_queued: got %h, required %h", g, 32'h3);
        end
        capture_frame(s1, d, ok);
        n_checks++;
        if (d !== 8'hA3 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: byte %h framing %b, required a3 / 1", d, ok);
        end
        capture_frame(s1 + 10 * C, d, ok);
        n_checks++;
        if (d !== 8'h0F || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: byte %h framing %b, required 0f / 1", d, ok);
        end
        bus_cycle(1'b0, 1'b1, 32'h4, 32'h0, e, g, x);
        n_checks++;
        if (g !== x || g !== 32'h1) begin
            n_fail++;
            $display("FAIL b2b_status_tail: got %h, required %h", g, 32'h1);
        end
        wait_until(end_last() + 2);
    endtask

    task automatic test_overrun();
        int          e, s1, lows;
        logic [31:0] g, x;
        logic [7:0]  d;
        logic        ok;
        bus_cycle(1'b1, 1'b0, 32'h0, 32'h11, e, g, x);
        s1 = e + 1;
        bus_cycle(1'b1, 1'b0, 32'h0, 32'h22, e, g, x);
        bus_cycle(1'b1, 1'b0, 32'h0, 32'h33, e, g, x);
        bus_cycle(1'b0, 1'b1, 32'h4, 32'h0, e, g, x);
        n_checks++;
        if (g !== x || g !== 32'h7) begin
            n_fail++;
            $display("FAIL overrun_first_read: got %h, required %h", g, 32'h7);
        end
        bus_cycle(1'b0, 1'b1, 32'h4, 32'h0, e, g, x);
        n_checks++;
        if (g !== x || g[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_cleared: got %h, required %h", g, x);
        end
        capture_frame(s1, d, ok);
        n_checks++;
        if (d !== 8'h11 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_frame1: byte %h framing %b, required 11 / 1", d, ok);
        end
        capture_frame(s1 + 10 * C, d, ok);
        n_checks++;
        if (d !== 8'h22 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_frame2: byte %h framing %b, required 22 / 1", d, ok);
        end
        wait_until(s1 + 20 * C);
        lows = 0;
        for (int k = 0; k < 10 * C + 5; k++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        n_checks++;
        if (lows !== 0) begin
            n_fail++;
            $display("FAIL overrun_dropped: %0d low samples after frame 2, required 0", lows);
        end
    endtask

    task automatic test_mid_reset();
        int          e, s;
        logic [31:0] g, x;
        logic [7:0]  d;
        logic        ok;
        bus_cycle(1'b1, 1'b0, 32'h0, 32'hFF, e, g, x);
        s = e + 1;
        wait_until(s + C * 4 + 1);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: txd=%b busy=%b, required 1/0", txd, busy);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        bus_cycle(1'b1, 1'b0, 32'h0, 32'h01, e, g, x);
        capture_frame(e + 1, d, ok);
        n_checks++;
        if (d !== 8'h01 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_frame: byte %h framing %b, required 01 / 1", d, ok);
        end
        wait_until(end_last() + 2);
    endtask

    task automatic test_decode();
        int          e, lows;
        logic [31:0] g, x;
        bus_cycle(1'b1, 1'b0, 32'h0, 32'h80, e, g, x);
        bus_cycle(1'b0, 1'b1, 32'h4, 32'h0, e, g, x);
        n_checks++;
        if (g !== x || g !== 32'h3) begin
            n_fail++;
            $display("FAIL decode_status: got %h, required %h", g, 32'h3);
        end
        bus_cycle(1'b1, 1'b0, 32'h4, 32'hFF, e, g, x);
        bus_cycle(1'b1, 1'b0, 32'h8, 32'hFF, e, g, x);
        bus_cycle(1'b1, 1'b0, 32'hC, 32'hFF, e, g, x);
        bus_cycle(1'b0, 1'b1, 32'h8, 32'h0, e, g, x);
        n_checks++;
        if (g !== x || g !== 32'h0) begin
            n_fail++;
            $display("FAIL decode_read8: got %h, required %h", g, 32'h0);
        end
        wait_until(end_last());
        lows = 0;
        for (int k = 0; k < 10 * C + 5; k++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        n_checks++;
        if (lows !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_no_frame: %0d low samples busy=%b, required 0 / 0", lows, busy);
        end
    endtask

    task automatic test_random();
        int          e, r, gap, burst;
        logic        wr, rd;
        logic [31:0] a, g, x;
        for (int it = 0; it < 200; it++) begin
            gap = $urandom_range(0, 50);
            for (int k = 0; k < gap; k++) begin
                bus_cycle(1'b0, 1'b0, 32'h0, 32'h0, e, g, x);
                n_checks++;
                if (g !== x) begin
                    n_fail++;
                    $display("FAIL rand_rdata_hold cyc=%0d: got %h, required %h", cyc, g, x);
                end
            end
            burst = $urandom_range(1, 3);
            for (int b = 0; b < burst; b++) begin
                r = $urandom_range(0, 9);
                if (r < 6)      a = 32'h0;
                else if (r < 9) a = 32'h4;
                else            a = ($urandom_range(0, 1) != 0) ? 32'h8 : 32'hC;
                wr = ($urandom_range(0, 3) != 0);
                rd = ($urandom_range(0, 2) == 0);
                bus_cycle(wr, rd, a, $urandom, e, g, x);
                n_checks++;
                if (g !== x) begin
                    n_fail++;
                    $display("FAIL rand_rdata cyc=%0d addr=%h wr=%b rd=%b: got %h, required %h",
                             cyc, a, wr, rd, g, x);
                end
            end
        end
        wait_until(end_last() + 2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
        test_decode();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
